// File: rtl/pc_next_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_next_unit: MIPS program counter and next-PC selection                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pc_next_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        Beq,
   input  logic        Bne,
   input  logic        BLTZ,
   input  logic        JMP,
   input  logic        JR,
   input  logic        JAL,
   input  logic        SH,
   input  logic        AluEqual,
   input  logic [31:0] R1,
   input  logic [31:0] I_imm,
   input  logic [31:0] J_imm,
   output logic        branch_ok,
   output logic [31:0] normal_pc,
   output logic [9:0]  addr
);

   logic [31:0] r_pc;
   logic [31:0] w_branch_pc;
   logic [31:0] w_j_pc;
   logic [31:0] w_jmp_pc;
   logic [31:0] w_next_pc;
   logic        w_branch;
   logic        w_bltz_branch;
   logic        w_r1_neg;

   // JAL and SH are decoded upstream; they steer nothing in this block.
   logic        w_unused;
   assign w_unused = &{1'b0, JAL, SH};

   assign normal_pc     = r_pc + 32'd4;
   assign w_branch_pc   = normal_pc + (I_imm << 2);
   assign w_j_pc        = J_imm << 2;
   assign w_jmp_pc      = JR ? R1 : w_j_pc;

   assign w_r1_neg      = R1[31];
   assign w_branch      = (Beq & AluEqual) | (Bne & ~AluEqual);
   assign w_bltz_branch = BLTZ & w_r1_neg;
   assign branch_ok     = w_branch | w_bltz_branch;

   // Jumps take priority over any branch condition.
   assign w_next_pc     = JMP ? w_jmp_pc : (branch_ok ? w_branch_pc : normal_pc);

   assign addr          = r_pc[11:2];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc <= 32'd0;
      end else if (enable) begin
         r_pc <= w_next_pc;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pc_next_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pc_next_unit: directed self-checking bench for pc_next_unit            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_pc_next_unit;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        Beq, Bne, BLTZ, JMP, JR, JAL, SH, AluEqual;
   logic [31:0] R1, I_imm, J_imm;
   logic        branch_ok;
   logic [31:0] normal_pc;
   logic [9:0]  addr;

   int n_checks = 0;
   int n_errors = 0;

   pc_next_unit dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .Beq       (Beq),
      .Bne       (Bne),
      .BLTZ      (BLTZ),
      .JMP       (JMP),
      .JR        (JR),
      .JAL       (JAL),
      .SH        (SH),
      .AluEqual  (AluEqual),
      .R1        (R1),
      .I_imm     (I_imm),
      .J_imm     (J_imm),
      .branch_ok (branch_ok),
      .normal_pc (normal_pc),
      .addr      (addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // PC is not a port; it is recovered as normal_pc - 4.
   task automatic chk_pc(input string tag, input logic [31:0] exp);
      chk(tag, normal_pc - 32'd4, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_ctrl();
      Beq = 0; Bne = 0; BLTZ = 0; JMP = 0; JR = 0; JAL = 0; SH = 0; AluEqual = 0;
   endtask

   task automatic load_pc(input logic [31:0] v);
      clr_ctrl();
      JMP = 1; JR = 1; R1 = v;
      step();
      clr_ctrl();
   endtask

   initial begin
      rst = 0; enable = 0;
      clr_ctrl();
      R1 = 0; I_imm = 0; J_imm = 0;
      #2;
      chk_pc("reset_pc", 32'h0);
      chk("reset_normal_pc", normal_pc, 32'h4);
      chk("reset_addr", {22'd0, addr}, 32'h0);

      @(negedge clk);
      rst = 1; enable = 1;
      step(); step(); step();
      chk_pc("seq_pc12", 32'd12);
      chk("seq_addr3", {22'd0, addr}, 32'd3);

      enable = 0;
      step(); step();
      chk_pc("hold_pc12", 32'd12);
      enable = 1;

      // BEQ / BNE from PC=0x10, offset -2 words
      I_imm = 32'hFFFF_FFFE;
      load_pc(32'h10);
      Beq = 1; AluEqual = 1; #1;
      chk("beq_taken_ok", {31'd0, branch_ok}, 32'd1);
      step();
      chk_pc("beq_taken_pc", 32'h0C);

      load_pc(32'h10);
      Beq = 1; AluEqual = 0; #1;
      chk("beq_not_ok", {31'd0, branch_ok}, 32'd0);
      step();
      chk_pc("beq_not_pc", 32'h14);

      load_pc(32'h10);
      Bne = 1; AluEqual = 0; #1;
      chk("bne_taken_ok", {31'd0, branch_ok}, 32'd1);
      step();
      chk_pc("bne_taken_pc", 32'h0C);

      // BLTZ from PC=0x20, offset +3 words
      I_imm = 32'd3;
      load_pc(32'h20);
      BLTZ = 1; R1 = 32'h8000_0000; #1;
      chk("bltz_neg_ok", {31'd0, branch_ok}, 32'd1);
      step();
      chk_pc("bltz_neg_pc", 32'h30);

      load_pc(32'h20);
      BLTZ = 1; R1 = 32'h0; #1;
      chk("bltz_zero_ok", {31'd0, branch_ok}, 32'd0);
      step();
      chk_pc("bltz_zero_pc", 32'h24);

      BLTZ = 1; R1 = 32'h7FFF_FFFF; #1;
      chk("bltz_maxpos_ok", {31'd0, branch_ok}, 32'd0);
      clr_ctrl();

      // Jumps from PC=0x40
      load_pc(32'h40);
      JMP = 1; JR = 0; J_imm = 32'h100;
      step();
      chk_pc("j_pc", 32'h400);

      load_pc(32'h40);
      JMP = 1; JR = 1; R1 = 32'h88;
      step();
      chk_pc("jr_pc", 32'h88);

      load_pc(32'h40);
      JMP = 1; JR = 0; J_imm = 32'h100; Beq = 1; AluEqual = 1; I_imm = 32'hFFFF_FFFE; #1;
      chk("jmp_over_beq_ok", {31'd0, branch_ok}, 32'd1);
      step();
      chk_pc("jmp_over_beq_pc", 32'h400);

      // Wrap-around
      load_pc(32'hFFFF_FFFC);
      chk("wrap_normal_pc", normal_pc, 32'h0);
      step();
      chk_pc("wrap_pc", 32'h0);

      load_pc(32'h0000_0FFC);
      chk("addr_max", {22'd0, addr}, 32'h3FF);

      // Asynchronous reset between edges
      load_pc(32'h50);
      chk_pc("pre_async_pc", 32'h50);
      #2 rst = 0;
      #1;
      chk_pc("async_rst_pc", 32'h0);
      chk("async_rst_addr", {22'd0, addr}, 32'h0);
      @(negedge clk);
      rst = 1;
      step();
      chk_pc("post_rst_pc", 32'h4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
